// File: rtl/comparador_debounce_if.sv
// +----------------------------------------------------------------------+
// | comparador_debounce_if: operand/button inputs and display-side outputs|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface comparador_debounce_if #(
    parameter int W = 3
);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         btn1;
    logic         btn2;
    logic         btn3;
    logic [5:0]   comparador;
    logic         b1;
    logic         b2;
    logic         b3;
    logic         valid;

    modport master (
        output a, b, btn1, btn2, btn3,
        input  comparador, b1, b2, b3, valid
    );

    modport slave (
        input  a, b, btn1, btn2, btn3,
        output comparador, b1, b2, b3, valid
    );
endinterface

`default_nettype wire

// File: rtl/comparador_debounce.sv
// +----------------------------------------------------------------------+
// | comparador_debounce: synchronized unsigned compare plus debounced     |
// | three-button toggle selector. Rev 1.0                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module comparador_debounce #(
    parameter int W        = 3,
    parameter int DEB_BITS = 20
) (
    input  wire logic              clk,
    input  wire logic              reset,
    comparador_debounce_if.slave   bus
);

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SEL1 = 2'd1,
        SEL2 = 2'd2,
        SEL3 = 2'd3
    } state_t;

    localparam logic [5:0]          CODE_EQ = 6'b010101;
    localparam logic [5:0]          CODE_LT = 6'b100110;
    localparam logic [5:0]          CODE_GT = 6'b001011;
    localparam logic [DEB_BITS-1:0] CNT_MAX = '1;
    localparam logic [DEB_BITS-1:0] CNT_ONE = {{(DEB_BITS-1){1'b0}}, 1'b1};

    // ---------------- compare pipeline ----------------
    logic [W-1:0] a_s0_q, a_s1_q, b_s0_q, b_s1_q;
    logic [1:0]   pipe_vld_q;
    logic [5:0]   cmp_q, cmp_d;
    logic         valid_q;

    always_comb begin
        if (a_s1_q == b_s1_q) begin
            cmp_d = CODE_EQ;
        end else if (a_s1_q < b_s1_q) begin
            cmp_d = CODE_LT;
        end else begin
            cmp_d = CODE_GT;
        end
    end

    // pipe_vld_q keeps the reset-cleared synchronizer contents from being compared
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_s0_q     <= '0;
            a_s1_q     <= '0;
            b_s0_q     <= '0;
            b_s1_q     <= '0;
            pipe_vld_q <= 2'b00;
            cmp_q      <= 6'b000000;
            valid_q    <= 1'b0;
        end else begin
            a_s0_q     <= bus.a;
            a_s1_q     <= a_s0_q;
            b_s0_q     <= bus.b;
            b_s1_q     <= b_s0_q;
            pipe_vld_q <= {pipe_vld_q[0], 1'b1};
            valid_q    <= 1'b0;
            if (pipe_vld_q[1]) begin
                cmp_q   <= cmp_d;
                valid_q <= (cmp_d != cmp_q);
            end
        end
    end

    // ---------------- button debounce ----------------
    logic [2:0]          btn_s0_q, btn_s1_q;
    logic [2:0]          stable_q, stable_d;
    logic [2:0]          press_q, press_d;
    logic [DEB_BITS-1:0] cnt_q [3];
    logic [DEB_BITS-1:0] cnt_d [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]    = '0;
            stable_d[i] = stable_q[i];
            press_d[i]  = 1'b0;
            if (btn_s1_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = btn_s1_q[i];
                    press_d[i]  = btn_s1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s0_q <= 3'b000;
            btn_s1_q <= 3'b000;
            stable_q <= 3'b000;
            press_q  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_s0_q <= {bus.btn3, bus.btn2, bus.btn1};
            btn_s1_q <= btn_s0_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ---------------- selection FSM ----------------
    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;

    always_comb begin
        state_d = state_q;
        sel_d   = 3'b000;
        if (press_q[0]) begin
            state_d = (state_q == SEL1) ? NONE : SEL1;
        end else if (press_q[1]) begin
            state_d = (state_q == SEL2) ? NONE : SEL2;
        end else if (press_q[2]) begin
            state_d = (state_q == SEL3) ? NONE : SEL3;
        end
        case (state_d)
            SEL1:    sel_d = 3'b001;
            SEL2:    sel_d = 3'b010;
            SEL3:    sel_d = 3'b100;
            default: sel_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= NONE;
            sel_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.comparador = cmp_q;
    assign bus.valid      = valid_q;
    assign bus.b1         = sel_q[0];
    assign bus.b2         = sel_q[1];
    assign bus.b3         = sel_q[2];

endmodule

`default_nettype wire

// File: doc/comparador_debounce.md
COMPARADOR_DEBOUNCE -- requirements
Module: comparador_debounce

Interface
REQ-001 SHALL have parameter W, default 3: unsigned operand width in bits.
REQ-002 SHALL have parameter DEB_BITS, default 20: debounce counter width; 2^20 cycles is about 21 ms at 50 MHz.
REQ-003 SHALL have port clk, input, 1 bit: single 50 MHz clock; all logic on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-low; logic resets on the clk edge where reset==0.
REQ-005 SHALL have port a, input, W bits: operand A from switches, asynchronous to clk.
REQ-006 SHALL have port b, input, W bits: operand B from switches, asynchronous to clk.
REQ-007 SHALL have ports btn1, btn2, btn3, input, 1 bit each: raw pushbuttons, active-high, bouncing, asynchronous.
REQ-008 SHALL have port comparador, output, 6 bits: registered comparison code feeding the display encoder.
REQ-009 SHALL have ports b1, b2, b3, output, 1 bit each: registered one-hot mode select feeding the display encoder.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse when comparador changes value.

Function
REQ-011 SHALL pass each btnN through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep one DEB_BITS counter and one stable bit per button.
- Synced level equals the stable bit: counter clears to 0.
- Synced level differs: counter increments.
- Counter reaches 2^DEB_BITS-1: stable bit takes the synced level and the counter clears on the same edge.
REQ-013 SHALL flag a button press when its stable bit goes 0->1; press flags are 1-cycle internal pulses.
REQ-014 SHALL run the selection state machine with states NONE, SEL1, SEL2 and SEL3.
- Output decoding: NONE gives b1=b2=b3=0; SELn drives only bn=1.
REQ-015 SHALL apply these transitions:
- A press of button n moves to SELn from any state other than SELn.
- A press of button n while already in SELn returns to NONE (toggle).
- No press: hold the current state.
REQ-016 SHALL resolve simultaneous press flags by priority btn1 > btn2 > btn3; lower-priority presses in that cycle are discarded.
REQ-017 SHALL pass a and b through 2-flop synchronizers (stage S0a/S0b).
- Stage S1 SHALL register the unsigned compare of the S0b values.
- a/b stable from edge k give the new comparador at edge k+3; latency is 3 cycles.
REQ-018 SHALL encode comparador as follows:
- a==b: 6'b010101.
- a<b: 6'b100110.
- a>b: 6'b001011.
- No other value is produced after reset.
REQ-019 SHALL assert valid for exactly the cycle after comparador is loaded with a value different from its previous value; a reload with an equal value gives no pulse.
REQ-020 SHALL compare full W-bit unsigned values with no sign extension; a=all-ones vs b=0 gives the a>b code.
REQ-021 SHALL keep the compare pipeline and the button path independent; a press never stalls or alters comparador.
REQ-022 SHALL reset the debounce counter to 0 on a bounce shorter than 2^DEB_BITS-1 cycles, producing no stable change.

Reset
REQ-023 SHALL, on a clk edge with reset==0, clear the synchronizers, counters, stable bits and press flags to 0.
REQ-024 SHALL, on a clk edge with reset==0, clear the state to NONE, b1=b2=b3=0, comparador=6'b000000 and valid=0.
REQ-025 SHALL abandon reset mid-debounce cleanly: a held button SHALL require a full 2^DEB_BITS-1 stable count after reset release before it registers.
REQ-026 SHALL produce the first post-reset comparador load with valid=1, since 000000 differs from every legal code.
REQ-027 SHALL keep the reset value of comparador outside the legal codes so the downstream encoder takes its non-matching branches until the first compare.

Verification (DEB_BITS=4 in simulation)
REQ-028 SHALL cover reset default output:
- Stimulus: reset low for 3 cycles, then high; a=3, b=3.
- Response: comparador=000000, valid=0 until edge 3; then comparador=010101 and valid=1 for one cycle.
REQ-029 SHALL cover compare codes:
- Stimulus: a=2, b=5, then a=7, b=0.
- Response: 100110, then 001011 three cycles after the change; valid pulses once per change.
REQ-030 SHALL cover debounce:
- Stimulus: btn2 toggling every 3 cycles for 30 cycles, then held high for 20 cycles.
- Response: no selection during bouncing; SEL2 (b2=1) appears 2 sync + 15 count cycles after the hold starts.
REQ-031 SHALL cover toggle:
- Stimulus: press btn1 and release, then press btn1 again.
- Response: b1=1 after the first press; b1=b2=b3=0 after the second.
REQ-032 SHALL cover simultaneous presses:
- Stimulus: btn1 and btn3 rise on the same cycle.
- Response: SEL1 only (b1=1, b3=0).
REQ-033 SHALL cover reset mid-operation:
- Stimulus: reset asserted while in SEL3 with btn3 held.
- Response: NONE and comparador=000000 next edge; no reselection until the full debounce count elapses after release of reset.
